// File: rtl/matrix_pkg.sv
// Shared constants, line storage type and FSM state encodings for the
// HUB75 receive path.
package matrix_pkg;

  localparam int MATRIX_COLUMNS    = 64;
  localparam int MATRIX_PLANES     = 6;
  localparam int MATRIX_ROW_BITS   = 4;
  localparam int MATRIX_PIXEL_BITS = 6;

  localparam int FB_COL_BITS   = 6;
  localparam int FB_ROW_BITS   = MATRIX_ROW_BITS;
  localparam int FB_PLANE_BITS = 3;
  localparam int FB_ADDR_BITS  = FB_PLANE_BITS + FB_ROW_BITS + FB_COL_BITS;

  // One full displayed line: element c is the pixel for column c.
  typedef logic [MATRIX_COLUMNS-1:0][MATRIX_PIXEL_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    CAP_SHIFT,
    CAP_WAIT_OE,
    CAP_DISPLAY,
    CAP_COMMIT
  } cap_state_t;

  typedef enum logic {
    DRAIN_EMPTY,
    DRAIN_ACTIVE
  } drain_state_t;

  // Bit-plane from OE pulse width: floor(log2 w) - 1, clamped to 0..5.
  function automatic logic [FB_PLANE_BITS-1:0] plane_from_width(input logic [31:0] w);
    logic [FB_PLANE_BITS-1:0] plane;
    if (w >= 32'd64)      plane = 3'd5;
    else if (w >= 32'd32) plane = 3'd4;
    else if (w >= 32'd16) plane = 3'd3;
    else if (w >= 32'd8)  plane = 3'd2;
    else if (w >= 32'd4)  plane = 3'd1;
    else                  plane = 3'd0;
    return plane;
  endfunction

endpackage

// File: rtl/hub_input_sync.sv
// Synchronises the asynchronous HUB75 inputs onto clk_in and produces
// single-cycle edge pulses for clk/lat/oe, with row and rgb delay-matched
// to those pulses.
module hub_input_sync
  import matrix_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         hub_clk,
  input  logic                         hub_lat,
  input  logic                         hub_oe,
  input  logic [MATRIX_ROW_BITS-1:0]   hub_row,
  input  logic [MATRIX_PIXEL_BITS-1:0] hub_rgb,
  output logic                         clk_rise,
  output logic                         lat_rise,
  output logic                         oe_rise,
  output logic                         oe_fall,
  output logic [MATRIX_ROW_BITS-1:0]   row,
  output logic [MATRIX_PIXEL_BITS-1:0] rgb
);

  localparam int BUS_W = 3 + MATRIX_ROW_BITS + MATRIX_PIXEL_BITS;

  // Bus layout: {clk, lat, oe, row, rgb}, all carried through the same flops.
  logic [SYNC_STAGES-1:0][BUS_W-1:0] sync_q;
  logic [BUS_W-1:0]                  edge_q;
  logic [2:0]                        prev_q;

  // Synchroniser chain, then the edge register and the previous control level.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      sync_q <= '0;
      edge_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= {hub_clk, hub_lat, hub_oe, hub_row, hub_rgb};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      edge_q <= sync_q[SYNC_STAGES-1];
      prev_q <= edge_q[BUS_W-1 -: 3];
    end
  end

  assign clk_rise = edge_q[BUS_W-1] & ~prev_q[2];
  assign lat_rise = edge_q[BUS_W-2] & ~prev_q[1];
  assign oe_rise  = edge_q[BUS_W-3] & ~prev_q[0];
  assign oe_fall  = ~edge_q[BUS_W-3] & prev_q[0];
  assign row      = edge_q[MATRIX_PIXEL_BITS +: MATRIX_ROW_BITS];
  assign rgb      = edge_q[MATRIX_PIXEL_BITS-1:0];

endmodule

// File: rtl/matrix_capture.sv
// HUB75 line capture: reassembles each latched 64-pixel line, tags it with
// row and bit-plane, and streams it out as framebuffer writes through a
// two-entry ping-pong line store.
// Optional feature: define MATRIX_CAPTURE_PLANE_DECODE_EN to derive the
// bit-plane from the OE pulse width instead of the per-row down-counter.
module matrix_capture
  import matrix_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int OE_CNT_WIDTH = 8
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         hub_clk,
  input  logic                         hub_lat,
  input  logic                         hub_oe,
  input  logic [MATRIX_ROW_BITS-1:0]   hub_row,
  input  logic [MATRIX_PIXEL_BITS-1:0] hub_rgb,
  output logic                         fb_wr_valid,
  input  logic                         fb_wr_ready,
  output logic [FB_ADDR_BITS-1:0]      fb_wr_addr,
  output logic [MATRIX_PIXEL_BITS-1:0] fb_wr_data,
  output logic                         err_shift,
  output logic                         err_short,
  output logic                         err_overflow,
  output logic                         err_oe
);

  logic                         clk_rise, lat_rise, oe_rise, oe_fall;
  logic [MATRIX_ROW_BITS-1:0]   sync_row;
  logic [MATRIX_PIXEL_BITS-1:0] sync_rgb;

  logic [6:0]             shift_cnt;
  logic [FB_COL_BITS-1:0] fill_col;
  line_t                  fill_line, closed_line;
  line_t                  line_buf [2];
  logic [FB_ROW_BITS-1:0]   buf_row   [2];
  logic [FB_PLANE_BITS-1:0] buf_plane [2];

  cap_state_t               cap_state, cap_next;
  logic [FB_ROW_BITS-1:0]   disp_row;
  logic [FB_PLANE_BITS-1:0] commit_plane;
  logic                     commit_fire, commit_take, commit_ok;

  drain_state_t           drain_state, drain_next;
  logic [1:0]             buf_count, count_next;
  logic                   wr_sel, rd_sel;
  logic [FB_COL_BITS-1:0] drain_col;
  logic                   beat, last_beat;

  hub_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in   (clk_in),
    .reset    (reset),
    .hub_clk  (hub_clk),
    .hub_lat  (hub_lat),
    .hub_oe   (hub_oe),
    .hub_row  (hub_row),
    .hub_rgb  (hub_rgb),
    .clk_rise (clk_rise),
    .lat_rise (lat_rise),
    .oe_rise  (oe_rise),
    .oe_fall  (oe_fall),
    .row      (sync_row),
    .rgb      (sync_rgb)
  );

  // First shifted pixel lands in the rightmost column.
  assign fill_col = 6'(MATRIX_COLUMNS - 1) - shift_cnt[5:0];

  // Shift-edge counter and the shift-length error flags; a latch wins over a coincident shift edge.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      shift_cnt <= '0;
      err_shift <= 1'b0;
      err_short <= 1'b0;
    end else if (lat_rise) begin
      shift_cnt <= '0;
      if (shift_cnt < 7'(MATRIX_COLUMNS)) err_short <= 1'b1;
    end else if (clk_rise) begin
      if (shift_cnt == 7'(MATRIX_COLUMNS)) err_shift <= 1'b1;
      else                                 shift_cnt <= shift_cnt + 7'd1;
    end
  end

  // Pixel storage: fill line, the closed line awaiting display, and the two drain buffers.
  always_ff @(posedge clk_in) begin
    if (clk_rise && !lat_rise && shift_cnt < 7'(MATRIX_COLUMNS)) fill_line[fill_col] <= sync_rgb;
    if (lat_rise) closed_line <= fill_line;
    if (commit_ok) begin
      line_buf[wr_sel]  <= closed_line;
      buf_row[wr_sel]   <= disp_row;
      buf_plane[wr_sel] <= commit_plane;
    end
  end

  // Capture FSM state register.
  always_ff @(posedge clk_in) begin
    if (!reset) cap_state <= CAP_SHIFT;
    else        cap_state <= cap_next;
  end

  // Capture FSM next state; a new latch always restarts the wait for OE.
  always_comb begin
    cap_next    = cap_state;
    commit_fire = 1'b0;
    case (cap_state)
      CAP_SHIFT:   if (lat_rise) cap_next = CAP_WAIT_OE;
      CAP_WAIT_OE: if (lat_rise) cap_next = CAP_WAIT_OE;
                   else if (oe_rise) cap_next = CAP_DISPLAY;
      CAP_DISPLAY: if (lat_rise) cap_next = CAP_WAIT_OE;
                   else if (oe_fall) cap_next = CAP_COMMIT;
      CAP_COMMIT: begin
        commit_fire = 1'b1;
        cap_next    = lat_rise ? CAP_WAIT_OE : CAP_SHIFT;
      end
      default:     cap_next = CAP_SHIFT;
    endcase
  end

  // Row is captured on the OE rising edge of the line being displayed.
  always_ff @(posedge clk_in) begin
    if (!reset) disp_row <= '0;
    else if (cap_state == CAP_WAIT_OE && oe_rise && !lat_rise) disp_row <= sync_row;
  end

`ifdef MATRIX_CAPTURE_PLANE_DECODE_EN
  logic [OE_CNT_WIDTH-1:0] oe_cnt;

  // OE width counter; counts every DISPLAY cycle including the falling-edge cycle, so it ends at the pulse width.
  always_ff @(posedge clk_in) begin
    if (!reset) oe_cnt <= '0;
    else if (cap_state == CAP_WAIT_OE && oe_rise && !lat_rise) oe_cnt <= '0;
    else if (cap_state == CAP_DISPLAY && oe_cnt != '1) oe_cnt <= oe_cnt + OE_CNT_WIDTH'(1);
  end

  assign commit_plane = plane_from_width(32'(oe_cnt));
  assign commit_take  = commit_fire && (32'(oe_cnt) >= 32'd2);

  // Too-short OE pulses are flagged and their line dropped.
  always_ff @(posedge clk_in) begin
    if (!reset) err_oe <= 1'b0;
    else if (commit_fire && !commit_take) err_oe <= 1'b1;
  end
`else
  logic [FB_ROW_BITS-1:0]   last_row;
  logic                     last_row_valid;
  logic [FB_PLANE_BITS-1:0] plane_cnt;

  // Bit-planes arrive MSB first per row: restart at the top plane on a new row, else step down and wrap.
  assign commit_plane = (!last_row_valid || disp_row != last_row || plane_cnt == '0)
                        ? 3'(MATRIX_PLANES - 1) : plane_cnt - 3'd1;
  assign commit_take  = commit_fire;
  assign err_oe       = 1'b0;

  // Remember the last committed row and plane for the down-counter.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      last_row       <= '0;
      last_row_valid <= 1'b0;
      plane_cnt      <= '0;
    end else if (commit_take) begin
      last_row       <= disp_row;
      last_row_valid <= 1'b1;
      plane_cnt      <= commit_plane;
    end
  end
`endif

  // A commit fits if a buffer is free, or if the final beat frees one in the same cycle.
  assign beat      = (drain_state == DRAIN_ACTIVE) && fb_wr_ready;
  assign last_beat = beat && (drain_col == '0);
  assign commit_ok = commit_take && (buf_count != 2'd2 || last_beat);

  // Drain FSM next state from the buffer occupancy after this cycle's commit and beat.
  always_comb begin
    count_next = buf_count;
    drain_next = drain_state;
    if (commit_ok && !last_beat)      count_next = buf_count + 2'd1;
    else if (!commit_ok && last_beat) count_next = buf_count - 2'd1;
    drain_next = (count_next != 2'd0) ? DRAIN_ACTIVE : DRAIN_EMPTY;
  end

  // Drain FSM state, buffer pointers, column counter and overflow flag.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      drain_state  <= DRAIN_EMPTY;
      buf_count    <= 2'd0;
      wr_sel       <= 1'b0;
      rd_sel       <= 1'b0;
      drain_col    <= '1;
      err_overflow <= 1'b0;
    end else begin
      drain_state <= drain_next;
      buf_count   <= count_next;
      if (commit_ok) wr_sel <= ~wr_sel;
      if (commit_take && !commit_ok) err_overflow <= 1'b1;
      if (last_beat) rd_sel <= ~rd_sel;
      if (beat) drain_col <= drain_col - 6'd1;
    end
  end

  assign fb_wr_valid = (drain_state == DRAIN_ACTIVE);
  assign fb_wr_addr  = fb_wr_valid ? {buf_plane[rd_sel], buf_row[rd_sel], drain_col} : '0;
  assign fb_wr_data  = fb_wr_valid ? line_buf[rd_sel][drain_col] : '0;

endmodule
